pc_unit: RTL and testbench

Program-counter register stage of the multicycle CPU, directly downstream of the PC-write qualification logic. It consumes the qualified PC write enable, selects the next PC from the datapath sources, and holds the PC and EPC registers. It also runs the exception-entry sequence:
- save EPC;
- read the handler address byte from the exception vector table in memory;
- load it into the PC.

---
 rtl/pc_unit.sv | 133 +++++++++++++
 tb/tb_pc_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit -- program-counter register stage of the multicycle CPU.
//
// Holds PC and EPC, selects the next PC from the datapath sources, and runs
// the exception-entry sequence:
//    - save EPC
//    - read the handler byte from the vector table
//    - load it into PC
//
// Parameters:
//    MEM_WAIT    cycles the vector address is held before mem_data is sampled (>=1)
//    VEC_BASE    byte address of the first exception vector entry
//
// Ports:
//    clk          system clock, rising edge
//    reset_n      asynchronous active-low reset
//    pc_write     qualified PC write enable
//    pc_src       next-PC select:
//                    0 alu_result, 1 alu_out, 2 jump, 3 epc, 4 reg_a, 5-7 hold
//    alu_result   combinational ALU result (PC+4 path)
//    alu_out      registered ALUOut (branch target)
//    jump_target  instruction bits [25:0]
//    reg_a        register A (jr)
//    exc_req      exception request, sampled only in IDLE
//    exc_code     0 invalid opcode, 1 overflow, 2/3 divide-by-zero
//    mem_data     vector byte returned by memory
//    pc           current program counter
//    epc          exception program counter
//    exc_addr     vector byte address while exc_busy, else 0
//    exc_busy     exception sequence in progress
//    exc_done     one-cycle pulse after PC is loaded with the handler address
module pc_unit #(
   parameter int unsigned MEM_WAIT = 2,
   parameter int unsigned VEC_BASE = 253
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pc_write,
   input  logic [2:0]  pc_src,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_out,
   input  logic [25:0] jump_target,
   input  logic [31:0] reg_a,
   input  logic        exc_req,
   input  logic [1:0]  exc_code,
   input  logic [7:0]  mem_data,
   output logic [31:0] pc,
   output logic [31:0] epc,
   output logic [31:0] exc_addr,
   output logic        exc_busy,
   output logic        exc_done
);

   localparam int unsigned CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEC_RD = 2'd1,
      VEC_LD = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [1:0]      code;

   // state register plus the PC/EPC datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         code     <= '0;
         pc       <= '0;
         epc      <= '0;
         exc_done <= 1'b0;
      end else begin
         state    <= state_nx;
         exc_done <= (state == VEC_LD);
         case (state)
            IDLE: begin
               // an exception request takes priority over the normal PC write
               if (exc_req) begin
                  epc  <= pc - 32'd4;
                  code <= (exc_code == 2'd3) ? 2'd2 : exc_code;
                  cnt  <= CW'(MEM_WAIT - 1);
               end else if (pc_write) begin
                  case (pc_src)
                     3'd0:    pc <= alu_result;
                     3'd1:    pc <= alu_out;
                     3'd2:    pc <= {pc[31:28], jump_target, 2'b00};
                     3'd3:    pc <= epc;
                     3'd4:    pc <= reg_a;
                     default: pc <= pc;
                  endcase
               end
            end
            VEC_RD: begin
               if (cnt != '0)
                  cnt <= cnt - CW'(1);
            end
            VEC_LD: begin
               pc <= {24'b0, mem_data};
            end
            default: ;
         endcase
      end
   end

   // next-state and state-decoded outputs
   always_comb begin
      state_nx = state;
      exc_busy = 1'b0;
      exc_addr = '0;
      case (state)
         IDLE: begin
            if (exc_req)
               state_nx = VEC_RD;
         end
         VEC_RD: begin
            exc_busy = 1'b1;
            exc_addr = VEC_BASE + {30'b0, code};
            if (cnt == '0)
               state_nx = VEC_LD;
         end
         VEC_LD: begin
            // address held through the sampling cycle so memory data stays valid
            exc_busy = 1'b1;
            exc_addr = VEC_BASE + {30'b0, code};
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed self-checking bench for pc_unit (MEM_WAIT=2, VEC_BASE=253).
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pc_write;
   logic [2:0]  pc_src;
   logic [31:0] alu_result;
   logic [31:0] alu_out;
   logic [25:0] jump_target;
   logic [31:0] reg_a;
   logic        exc_req;
   logic [1:0]  exc_code;
   logic [7:0]  mem_data;
   logic [31:0] pc;
   logic [31:0] epc;
   logic [31:0] exc_addr;
   logic        exc_busy;
   logic        exc_done;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   pc_unit #(
      .MEM_WAIT (2),
      .VEC_BASE (253)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .alu_result  (alu_result),
      .alu_out     (alu_out),
      .jump_target (jump_target),
      .reg_a       (reg_a),
      .exc_req     (exc_req),
      .exc_code    (exc_code),
      .mem_data    (mem_data),
      .pc          (pc),
      .epc         (epc),
      .exc_addr    (exc_addr),
      .exc_busy    (exc_busy),
      .exc_done    (exc_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 3'd0;
      alu_result  = '0;
      alu_out     = '0;
      jump_target = '0;
      reg_a       = '0;
      exc_req     = 1'b0;
      exc_code    = 2'd0;
      mem_data    = 8'h55;
      step();
      step();
      reset_n = 1'b1;
      step();

      // reset state
      chk("rst_pc",   pc,       32'h0);
      chk("rst_epc",  epc,      32'h0);
      chk("rst_busy", {31'b0, exc_busy}, 32'h0);
      chk("rst_addr", exc_addr, 32'h0);
      chk("rst_done", {31'b0, exc_done}, 32'h0);

      // source select
      pc_write = 1'b1; pc_src = 3'd0; alu_result = 32'h0040_0010;
      step();
      chk("src0_pc", pc, 32'h0040_0010);
      pc_src = 3'd2; jump_target = 26'h000_0100;
      step();
      chk("jump_pc", pc, 32'h0000_0400);
      pc_src = 3'd1; alu_out = 32'h0000_1234;
      step();
      chk("aluout_pc", pc, 32'h0000_1234);
      pc_src = 3'd4; reg_a = 32'hDEAD_BEEC;
      step();
      chk("rega_pc", pc, 32'hDEAD_BEEC);
      pc_src = 3'd2; jump_target = 26'h3FF_FFFF;
      step();
      chk("jump_hi_pc", pc, 32'hDFFF_FFFC);
      pc_src = 3'd6; alu_result = 32'h0000_0999;
      step();
      chk("hold6_pc", pc, 32'hDFFF_FFFC);
      pc_write = 1'b0; pc_src = 3'd0;
      step();
      chk("nowrite_pc", pc, 32'hDFFF_FFFC);

      // overflow exception
      pc_write = 1'b1; pc_src = 3'd0; alu_result = 32'h0000_0108;
      step();
      chk("pre_exc_pc", pc, 32'h0000_0108);
      pc_write = 1'b0; exc_req = 1'b1; exc_code = 2'd1; mem_data = 8'h55;
      step();                                   // E0
      exc_req = 1'b0;
      chk("ov_epc",   epc,      32'h0000_0104);
      chk("ov_busy0", {31'b0, exc_busy}, 32'h1);
      chk("ov_addr0", exc_addr, 32'd254);
      chk("ov_pc0",   pc,       32'h0000_0108);
      step();                                   // E0+1
      chk("ov_addr1", exc_addr, 32'd254);
      chk("ov_busy1", {31'b0, exc_busy}, 32'h1);
      step();                                   // E0+2, VEC_LD cycle
      mem_data = 8'h80;
      chk("ov_busy2", {31'b0, exc_busy}, 32'h1);
      chk("ov_pc2",   pc, 32'h0000_0108);
      chk("ov_done2", {31'b0, exc_done}, 32'h0);
      step();                                   // E0+3
      mem_data = 8'h55;
      chk("ov_pc3",   pc, 32'h0000_0080);
      chk("ov_done3", {31'b0, exc_done}, 32'h1);
      chk("ov_busy3", {31'b0, exc_busy}, 32'h0);
      chk("ov_addr3", exc_addr, 32'h0);
      step();
      chk("ov_done4", {31'b0, exc_done}, 32'h0);
      chk("ov_epc4",  epc, 32'h0000_0104);

      // return through epc
      pc_write = 1'b1; pc_src = 3'd3;
      step();
      chk("epc_src_pc", pc, 32'h0000_0104);

      // simultaneous exc_req and pc_write, code 3
      pc_src = 3'd0; alu_result = 32'h0000_01FC;
      step();
      alu_result = 32'h0000_0200; exc_req = 1'b1; exc_code = 2'd3;
      step();                                   // E0
      chk("sim_pc",   pc,       32'h0000_01FC);
      chk("sim_epc",  epc,      32'h0000_01F8);
      chk("sim_addr", exc_addr, 32'd255);

      // busy lockout
      exc_code = 2'd0; alu_result = 32'h0000_0300;
      step();                                   // E0+1
      chk("lock_epc",  epc,      32'h0000_01F8);
      chk("lock_addr", exc_addr, 32'd255);
      chk("lock_pc",   pc,       32'h0000_01FC);
      step();                                   // E0+2, VEC_LD cycle
      exc_req = 1'b0; pc_write = 1'b0; mem_data = 8'hA0;
      chk("lock_addr2", exc_addr, 32'd255);
      step();                                   // E0+3
      mem_data = 8'h55;
      chk("lock_pc3",   pc, 32'h0000_00A0);
      chk("lock_done3", {31'b0, exc_done}, 32'h1);

      // back-to-back: request during the exc_done cycle
      exc_req = 1'b1; exc_code = 2'd2;
      step();
      exc_req = 1'b0;
      chk("b2b_epc",  epc,      32'h0000_009C);
      chk("b2b_busy", {31'b0, exc_busy}, 32'h1);
      chk("b2b_addr", exc_addr, 32'd255);
      chk("b2b_done", {31'b0, exc_done}, 32'h0);

      // asynchronous reset mid VEC_RD
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_pc",   pc,       32'h0);
      chk("arst_epc",  epc,      32'h0);
      chk("arst_busy", {31'b0, exc_busy}, 32'h0);
      chk("arst_addr", exc_addr, 32'h0);
      chk("arst_done", {31'b0, exc_done}, 32'h0);
      #1;
      reset_n = 1'b1;
      pc_write = 1'b1; pc_src = 3'd0; alu_result = 32'h0000_0004;
      step();
      chk("post_rst_pc",   pc, 32'h0000_0004);
      chk("post_rst_busy", {31'b0, exc_busy}, 32'h0);
      pc_write = 1'b0;
      step();
      step();
      chk("post_rst_hold", pc, 32'h0000_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
